// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: parity encodings, FSM states, idle line level.
// Constants only; no logic, no latency, no flow control.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit word FIFO; push visible at the next edge, combinational head read.
// Pushes while full are dropped and flagged by a one-cycle registered overflow pulse.
module uart_tx_fifo #(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [WORD_SIZE-1:0] rd_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;

    // Full is judged on the registered flag, so a same-cycle pop never frees a slot early.
    assign push = wr_en_i && !full_q;
    assign pop  = rd_en_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            full_q     <= (count_d == CW'(FIFO_DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= wr_en_i && full_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_xmtr_fifo.sv
// FIFO-fed UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits.
// Start bit drives from the edge after the pop; back-to-back frames have no idle gap.
module uart_xmtr_fifo
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 Clock,
    input  logic                 rst_b,
    input  logic [WORD_SIZE-1:0] Data_Bus,
    input  logic                 wr_en,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 Serial_out
);

    localparam int BAUDW = $clog2(CLKS_PER_BIT);
    localparam int BITW  = $clog2(WORD_SIZE);
    localparam logic [BAUDW-1:0] BAUD_LAST = BAUDW'(CLKS_PER_BIT - 1);
    localparam logic [BITW-1:0]  BIT_LAST  = BITW'(WORD_SIZE - 1);

    state_e               state_q;
    logic [BAUDW-1:0]     baud_q;
    logic [BITW-1:0]      bit_q;
    logic [WORD_SIZE-1:0] shift_q;
    logic                 par_bit_q;
    logic [1:0]           par_mode_q;
    logic                 two_stop_q;
    logic                 stop2_q;
    logic                 serial_q;
    logic                 busy_q;

    logic [WORD_SIZE-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 last_stop;
    logic                 pop;

    uart_tx_fifo #(
        .WORD_SIZE  (WORD_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (Clock),
        .rst_i      (rst_b),
        .wr_en_i    (wr_en),
        .wr_data_i  (Data_Bus),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_data),
        .full_o     (full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign bit_end   = (baud_q == BAUD_LAST);
    assign last_stop = !two_stop_q || stop2_q;
    assign pop       = !fifo_empty &&
                       ((state_q == IDLE) || (state_q == STOP && bit_end && last_stop));

    // A pop always starts a new frame, whether from IDLE or straight out of the last stop bit.
    always_ff @(posedge Clock or posedge rst_b) begin
        if (rst_b) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            serial_q   <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            if (state_q != IDLE) begin
                baud_q <= bit_end ? '0 : baud_q + BAUDW'(1);
            end
            if (pop) begin
                state_q    <= START;
                baud_q     <= '0;
                shift_q    <= fifo_data;
                par_mode_q <= parity_mode;
                two_stop_q <= two_stop;
                par_bit_q  <= (^fifo_data) ^ (parity_mode == PAR_ODD);
                stop2_q    <= 1'b0;
                serial_q   <= 1'b0;
                busy_q     <= 1'b1;
            end else if (bit_end) begin
                case (state_q)
                    START: begin
                        state_q  <= DATA;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bit_q    <= '0;
                    end
                    DATA: begin
                        if (bit_q != BIT_LAST) begin
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bit_q    <= bit_q + BITW'(1);
                        end else if (par_mode_q == PAR_EVEN || par_mode_q == PAR_ODD) begin
                            state_q  <= PARITY;
                            serial_q <= par_bit_q;
                        end else begin
                            state_q  <= STOP;
                            serial_q <= IDLE_LEVEL;
                        end
                    end
                    PARITY: begin
                        state_q  <= STOP;
                        serial_q <= IDLE_LEVEL;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop2_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign empty      = fifo_empty;
    assign busy       = busy_q;
    assign Serial_out = serial_q;

endmodule

// File: tb/tb_uart_xmtr_fifo.sv
// Directed bench for uart_xmtr_fifo with WORD_SIZE=8, FIFO_DEPTH=4, CLKS_PER_BIT=4.
// Expected line sequences are hand-built frame vectors, bit 0 sent first.
module tb_uart_xmtr_fifo;

    localparam int WS  = 8;
    localparam int FD  = 4;
    localparam int CPB = 4;

    logic          Clock = 1'b0;
    logic          rst_b;
    logic [WS-1:0] Data_Bus;
    logic          wr_en;
    logic [1:0]    parity_mode;
    logic          two_stop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          overflow;
    logic          Serial_out;

    int checks = 0;
    int errors = 0;

    uart_xmtr_fifo #(
        .WORD_SIZE    (WS),
        .FIFO_DEPTH   (FD),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .Clock       (Clock),
        .rst_b       (rst_b),
        .Data_Bus    (Data_Bus),
        .wr_en       (wr_en),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .overflow    (overflow),
        .Serial_out  (Serial_out)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Checks line cycles first..last of a frame, one check per clock.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int first,
                               input int last);
        for (int c = first; c <= last; c++) begin
            chk(tag, {31'b0, Serial_out}, {31'b0, bits[c / CPB]});
            tick();
        end
    endtask

    // No parity, one stop bit: start, 8 data bits, stop.
    function automatic logic [15:0] frame_np(input logic [7:0] w);
        return {6'b0, 1'b1, w, 1'b0};
    endfunction

    logic [7:0] six_w [6];
    logic [7:0] pp_w  [6];

    initial begin
        six_w = '{8'h3C, 8'h81, 8'h5A, 8'hF0, 8'h0F, 8'hEE};
        pp_w  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst_b = 1'b1; wr_en = 1'b0; Data_Bus = '0; parity_mode = 2'b00; two_stop = 1'b0;
        tick(); tick();
        chk("rst_serial", {31'b0, Serial_out}, 32'd1);
        chk("rst_empty",  {31'b0, empty},      32'd1);
        chk("rst_full",   {31'b0, full},       32'd0);
        chk("rst_busy",   {31'b0, busy},       32'd0);
        chk("rst_ovf",    {31'b0, overflow},   32'd0);
        rst_b = 1'b0;
        tick();

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        Data_Bus = 8'hA5; wr_en = 1'b1; tick(); wr_en = 1'b0;
        chk("a5_wr_empty",  {31'b0, empty},      32'd0);
        chk("a5_wr_serial", {31'b0, Serial_out}, 32'd1);
        chk("a5_wr_busy",   {31'b0, busy},       32'd0);
        tick();
        chk("a5_busy",      {31'b0, busy},       32'd1);
        chk("a5_pop_empty", {31'b0, empty},      32'd1);
        check_frame("a5_none", 16'h034A, 0, 10 * CPB - 1);
        chk("a5_idle_busy",   {31'b0, busy},       32'd0);
        chk("a5_idle_serial", {31'b0, Serial_out}, 32'd1);

        // Even parity of 0xA5 is 0
        parity_mode = 2'b01;
        Data_Bus = 8'hA5; wr_en = 1'b1; tick(); wr_en = 1'b0; tick();
        check_frame("a5_even", {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 0, 11 * CPB - 1);
        chk("even_idle_busy", {31'b0, busy}, 32'd0);

        // Odd parity bit 1, two stop bits
        parity_mode = 2'b10; two_stop = 1'b1;
        Data_Bus = 8'hA5; wr_en = 1'b1; tick(); wr_en = 1'b0; tick();
        check_frame("a5_odd_2stop", {4'b0, 2'b11, 1'b1, 8'hA5, 1'b0}, 0, 12 * CPB - 1);
        chk("odd_idle_busy", {31'b0, busy}, 32'd0);
        parity_mode = 2'b00; two_stop = 1'b0;

        // Six back-to-back writes: first pop at edge 1, full after the 5th, 6th overflows
        for (int i = 0; i < 6; i++) begin
            Data_Bus = six_w[i]; wr_en = 1'b1; tick();
            if (i == 3) chk("six_full_3", {31'b0, full}, 32'd0);
            if (i == 4) chk("six_full_4", {31'b0, full}, 32'd1);
            if (i == 5) begin
                chk("six_full_5", {31'b0, full},     32'd1);
                chk("six_ovf",    {31'b0, overflow}, 32'd1);
            end
        end
        wr_en = 1'b0;
        check_frame("six_f0", frame_np(six_w[0]), 4, 4);
        chk("six_ovf_pulse", {31'b0, overflow}, 32'd0);
        check_frame("six_f0", frame_np(six_w[0]), 5, 10 * CPB - 1);
        check_frame("six_f1", frame_np(six_w[1]), 0, 10 * CPB - 1);
        check_frame("six_f2", frame_np(six_w[2]), 0, 10 * CPB - 1);
        check_frame("six_f3", frame_np(six_w[3]), 0, 10 * CPB - 1);
        check_frame("six_f4", frame_np(six_w[4]), 0, 10 * CPB - 1);
        chk("six_end_busy",  {31'b0, busy},  32'd0);
        chk("six_end_empty", {31'b0, empty}, 32'd1);

        // Push and pop together at count 2: two more writes must then exactly fill the FIFO
        for (int i = 0; i < 3; i++) begin
            Data_Bus = pp_w[i]; wr_en = 1'b1; tick();
        end
        wr_en = 1'b0;
        check_frame("pp_fa", frame_np(pp_w[0]), 1, 10 * CPB - 2);
        Data_Bus = pp_w[3]; wr_en = 1'b1;
        chk("pp_fa_last", {31'b0, Serial_out}, 32'd1);
        tick();
        chk("pp_full_2",  {31'b0, full},  32'd0);
        chk("pp_empty_2", {31'b0, empty}, 32'd0);
        Data_Bus = pp_w[4]; tick();
        chk("pp_full_3", {31'b0, full}, 32'd0);
        Data_Bus = pp_w[5]; tick();
        wr_en = 1'b0;
        chk("pp_full_4", {31'b0, full}, 32'd1);
        check_frame("pp_fb", frame_np(pp_w[1]), 2, 10 * CPB - 1);
        for (int i = 2; i < 6; i++) begin
            check_frame("pp_order", frame_np(pp_w[i]), 0, 10 * CPB - 1);
        end
        chk("pp_end_busy", {31'b0, busy}, 32'd0);

        // Parity switched to odd mid-frame: 0x37 first without parity, then with odd bit 0
        Data_Bus = 8'h37; wr_en = 1'b1; tick();
        Data_Bus = 8'h37; tick();
        wr_en = 1'b0; parity_mode = 2'b10;
        check_frame("mid_none", {6'b0, 1'b1, 8'h37, 1'b0}, 0, 10 * CPB - 1);
        check_frame("mid_odd",  {5'b0, 1'b1, 1'b0, 8'h37, 1'b0}, 0, 11 * CPB - 1);
        chk("mid_end_busy", {31'b0, busy}, 32'd0);
        parity_mode = 2'b00;

        // Reset during a start bit with one word still queued
        Data_Bus = 8'h5A; wr_en = 1'b1; tick();
        Data_Bus = 8'hC3; tick();
        wr_en = 1'b0;
        chk("prerst_serial", {31'b0, Serial_out}, 32'd0);
        chk("prerst_empty",  {31'b0, empty},      32'd0);
        rst_b = 1'b1;
        #1;
        chk("rst_async_serial", {31'b0, Serial_out}, 32'd1);
        tick();
        chk("midrst_serial", {31'b0, Serial_out}, 32'd1);
        chk("midrst_empty",  {31'b0, empty},      32'd1);
        chk("midrst_busy",   {31'b0, busy},       32'd0);
        chk("midrst_full",   {31'b0, full},       32'd0);
        rst_b = 1'b0;
        tick(); tick();
        chk("postrst_busy",   {31'b0, busy},       32'd0);
        chk("postrst_serial", {31'b0, Serial_out}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
